conv_sequencer: RTL and testbench

Control FSM for the single-MAC convolution datapath: x sample memory, f coefficient ROM and saturating accumulator. It sequences three phases and repeats them for every input vector:
- load LENX input samples into the x memory through a valid/ready slave handshake;
- for each of the LENX-LENF+1 output positions, clear the accumulator, issue LENF read-address pairs and enable accumulation with the memory read latency applied;
- present each result on a valid/ready master handshake.

It owns no arithmetic. The datapath consumes its address and strobe outputs.

---
 rtl/conv_pkg.sv | 12 +
 rtl/conv_seq_addr_gen.sv | 75 +++++++
 rtl/conv_sequencer.sv | 121 ++++++++++++
 tb/tb_conv_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer and its datapath testbenches.
package conv_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLR   = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } conv_state_t;

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Tap and output-position counters that turn the sequencer state into
// x memory / coefficient ROM read addresses.
module conv_seq_addr_gen
  import conv_pkg::*;
#(
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int ADDRX = 6,
  parameter int ADDRF = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  conv_state_t       i_state,
  input  logic [ADDRX-1:0]  i_wr_cnt,
  input  logic              i_tap_step,
  input  logic              i_out_next,
  input  logic              i_out_restart,
  output logic [ADDRX-1:0]  o_mem_addr_x,
  output logic [ADDRF-1:0]  o_rom_addr_f,
  output logic              o_last_tap,
  output logic              o_last_out
);

  localparam logic [ADDRF-1:0] LAST_TAP = ADDRF'(LENF - 1);
  localparam logic [ADDRX-1:0] LAST_OUT = ADDRX'(LENX - LENF);

  logic [ADDRF-1:0] r_tap;
  logic [ADDRX-1:0] r_out_idx;
  logic [ADDRX-1:0] w_rd_addr;

  // tap holds at LENF-1 after MAC so addresses stay frozen through DRAIN and OUT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tap     <= {ADDRF{1'b0}};
      r_out_idx <= {ADDRX{1'b0}};
    end else if (i_out_restart) begin
      r_tap     <= {ADDRF{1'b0}};
      r_out_idx <= {ADDRX{1'b0}};
    end else if (i_out_next) begin
      r_tap     <= {ADDRF{1'b0}};
      r_out_idx <= r_out_idx + ADDRX'(1);
    end else if (i_tap_step) begin
      r_tap     <= r_tap + ADDRF'(1);
      r_out_idx <= r_out_idx;
    end else begin
      r_tap     <= r_tap;
      r_out_idx <= r_out_idx;
    end
  end

  assign w_rd_addr  = r_out_idx + ADDRX'(r_tap);
  assign o_last_tap = (r_tap == LAST_TAP);
  assign o_last_out = (r_out_idx == LAST_OUT);

  // Address mux: write counter during LOAD, ROM address parked at 0 until MAC
  always_comb begin
    o_mem_addr_x = w_rd_addr;
    o_rom_addr_f = r_tap;
    case (i_state)
      LOAD: begin
        o_mem_addr_x = i_wr_cnt;
        o_rom_addr_f = {ADDRF{1'b0}};
      end
      CLR: begin
        o_mem_addr_x = w_rd_addr;
        o_rom_addr_f = {ADDRF{1'b0}};
      end
      default: begin
        o_mem_addr_x = w_rd_addr;
        o_rom_addr_f = r_tap;
      end
    endcase
  end

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for the single-MAC convolution datapath: loads a vector, then
// sequences clear / multiply-accumulate / drain / output for each position.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int ADDRX = 6,
  parameter int ADDRF = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid_x,
  output logic              s_ready_x,
  output logic              mem_wr_en,
  output logic [ADDRX-1:0]  mem_addr_x,
  output logic [ADDRF-1:0]  rom_addr_f,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              m_valid_y,
  input  logic              m_ready_y,
  output logic              busy
);

  localparam logic [ADDRX-1:0] LAST_WR = ADDRX'(LENX - 1);

  conv_state_t      r_state;
  conv_state_t      w_next_state;
  logic             r_started;
  logic [ADDRX-1:0] r_wr_cnt;
  logic             r_acc_en;
  logic             w_load_hs;
  logic             w_load_last;
  logic             w_accept;
  logic             w_last_tap;
  logic             w_last_out;

  assign s_ready_x   = (r_state == LOAD) & r_started;
  assign w_load_hs   = s_valid_x & s_ready_x;
  assign w_load_last = w_load_hs & (r_wr_cnt == LAST_WR);
  assign w_accept    = (r_state == OUT) & m_ready_y;

  assign mem_wr_en = w_load_hs;
  assign acc_clr   = (r_state == CLR);
  assign acc_en    = r_acc_en;
  assign m_valid_y = (r_state == OUT);
  assign busy      = (r_state != LOAD);

  // State register plus the started gate that keeps s_ready_x low in the release cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= LOAD;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_started <= 1'b1;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOAD: begin
        if (w_load_last) w_next_state = CLR;
        else             w_next_state = LOAD;
      end
      CLR:   w_next_state = MAC;
      MAC: begin
        if (w_last_tap) w_next_state = DRAIN;
        else            w_next_state = MAC;
      end
      DRAIN: w_next_state = OUT;
      OUT: begin
        if (m_ready_y && w_last_out) w_next_state = LOAD;
        else if (m_ready_y)          w_next_state = CLR;
        else                         w_next_state = OUT;
      end
      default: w_next_state = LOAD;
    endcase
  end

  // Write counter for the sample load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt <= {ADDRX{1'b0}};
    end else if (w_load_last) begin
      r_wr_cnt <= {ADDRX{1'b0}};
    end else if (w_load_hs) begin
      r_wr_cnt <= r_wr_cnt + ADDRX'(1);
    end else begin
      r_wr_cnt <= r_wr_cnt;
    end
  end

  // acc_en trails the MAC address by one cycle to match the memory read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_acc_en <= 1'b0;
    else        r_acc_en <= (r_state == MAC);
  end

  conv_seq_addr_gen #(
    .LENX  (LENX),
    .LENF  (LENF),
    .ADDRX (ADDRX),
    .ADDRF (ADDRF)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .i_state       (r_state),
    .i_wr_cnt      (r_wr_cnt),
    .i_tap_step    ((r_state == MAC) & ~w_last_tap),
    .i_out_next    (w_accept & ~w_last_out),
    .i_out_restart (w_load_last | (w_accept & w_last_out)),
    .o_mem_addr_x  (mem_addr_x),
    .o_rom_addr_f  (rom_addr_f),
    .o_last_tap    (w_last_tap),
    .o_last_out    (w_last_out)
  );

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer with LENX=8, LENF=4 (5 outputs).
module tb_conv_sequencer;

  localparam int LENX  = 8;
  localparam int LENF  = 4;
  localparam int ADDRX = 3;
  localparam int ADDRF = 2;
  localparam int NOUT  = LENX - LENF + 1;

  logic             clk;
  logic             reset;
  logic             s_valid_x;
  logic             s_ready_x;
  logic             mem_wr_en;
  logic [ADDRX-1:0] mem_addr_x;
  logic [ADDRF-1:0] rom_addr_f;
  logic             acc_clr;
  logic             acc_en;
  logic             m_valid_y;
  logic             m_ready_y;
  logic             busy;

  int n_tests;
  int n_fail;
  int n_accepts;

  // flags = {s_ready_x, mem_wr_en, acc_clr, acc_en, m_valid_y, busy}
  logic [5:0] flags;
  assign flags = {s_ready_x, mem_wr_en, acc_clr, acc_en, m_valid_y, busy};

  conv_sequencer #(
    .LENX (LENX), .LENF (LENF), .ADDRX (ADDRX), .ADDRF (ADDRF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid_x  (s_valid_x),
    .s_ready_x  (s_ready_x),
    .mem_wr_en  (mem_wr_en),
    .mem_addr_x (mem_addr_x),
    .rom_addr_f (rom_addr_f),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .m_valid_y  (m_valid_y),
    .m_ready_y  (m_ready_y),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts at the CLR cycle of output idx; returns at the start of the cycle after its accept.
  task automatic run_output(input int idx, input int stall);
    logic [5:0] ef;
    m_ready_y = (stall == 0);
    #1;
    n_tests++;
    if ({flags, mem_addr_x, rom_addr_f} !== {6'b001001, 3'(idx), 2'd0}) begin
      n_fail++;
      $display("FAIL clr_cycle out%0d: flags=%b addr=%0d rom=%0d, want flags=001001 addr=%0d rom=0",
               idx, flags, mem_addr_x, rom_addr_f, idx);
    end
    tick();
    for (int k = 0; k < LENF; k++) begin
      #1;
      ef = {4'b0000, 1'b0, 1'b1};
      ef[2] = (k != 0);
      n_tests++;
      if ({flags, mem_addr_x, rom_addr_f} !== {ef, 3'(idx + k), 2'(k)}) begin
        n_fail++;
        $display("FAIL mac out%0d tap%0d: flags=%b addr=%0d rom=%0d, want flags=%b addr=%0d rom=%0d",
                 idx, k, flags, mem_addr_x, rom_addr_f, ef, idx + k, k);
      end
      tick();
    end
    #1;
    n_tests++;
    if (flags !== 6'b000101) begin
      n_fail++;
      $display("FAIL drain out%0d: flags=%b want 000101", idx, flags);
    end
    tick();
    for (int s = 0; s < stall; s++) begin
      #1;
      n_tests++;
      if ({flags, mem_addr_x, rom_addr_f} !== {6'b000011, 3'(idx + LENF - 1), 2'(LENF - 1)}) begin
        n_fail++;
        $display("FAIL stall out%0d cyc%0d: flags=%b addr=%0d rom=%0d, want flags=000011 addr=%0d rom=%0d",
                 idx, s, flags, mem_addr_x, rom_addr_f, idx + LENF - 1, LENF - 1);
      end
      tick();
    end
    m_ready_y = 1'b1;
    #1;
    n_tests++;
    if ({flags, mem_addr_x, rom_addr_f} !== {6'b000011, 3'(idx + LENF - 1), 2'(LENF - 1)}) begin
      n_fail++;
      $display("FAIL out_accept out%0d: flags=%b addr=%0d rom=%0d, want flags=000011 addr=%0d",
               idx, flags, mem_addr_x, rom_addr_f, idx + LENF - 1);
    end
    if (m_valid_y === 1'b1) n_accepts++;
    tick();
    m_ready_y = (stall == 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid_x = 1'b0; m_ready_y = 1'b0;
    repeat (3) tick();
    #1;
    n_tests++;
    if ({flags, mem_addr_x, rom_addr_f} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %b want all zero", {flags, mem_addr_x, rom_addr_f});
    end
    reset = 1'b1;
    s_valid_x = 1'b1;
    #1;
    n_tests++;
    if ({s_ready_x, mem_wr_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL release_cycle: s_ready=%b wr_en=%b want 0 0", s_ready_x, mem_wr_en);
    end
    s_valid_x = 1'b0;
    tick();
    #1;
    n_tests++;
    if (flags !== 6'b100000) begin
      n_fail++;
      $display("FAIL first_ready: flags=%b want 100000", flags);
    end
  endtask

  task automatic test_load(input string tag, input bit gaps);
    int w;
    w = 0;
    for (int j = 0; w < LENX && j < 4 * LENX; j++) begin
      s_valid_x = gaps ? (j % 2 == 0) : 1'b1;
      #1;
      n_tests++;
      if ({flags, mem_addr_x, rom_addr_f} !== {1'b1, s_valid_x, 4'b0000, 3'(w), 2'd0}) begin
        n_fail++;
        $display("FAIL %s cyc%0d: flags=%b addr=%0d rom=%0d, want flags=1%0b0000 addr=%0d rom=0",
                 tag, j, flags, mem_addr_x, rom_addr_f, s_valid_x, w);
      end
      if (s_valid_x) w++;
      tick();
    end
    // s_valid_x stays high into compute to prove it is ignored while busy
    s_valid_x = 1'b1;
  endtask

  task automatic test_backpressure();
    n_accepts = 0;
    run_output(0, 10);
  endtask

  task automatic test_full_run();
    for (int i = 1; i < NOUT; i++) run_output(i, 0);
    s_valid_x = 1'b0;
    #1;
    n_tests++;
    if (n_accepts !== NOUT) begin
      n_fail++;
      $display("FAIL accept_count: got %0d want %0d", n_accepts, NOUT);
    end
    n_tests++;
    if ({flags, mem_addr_x, rom_addr_f} !== {6'b100000, 3'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL back_to_load: flags=%b addr=%0d rom=%0d want flags=100000 addr=0 rom=0",
               flags, mem_addr_x, rom_addr_f);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    run_output(0, 0);
    run_output(1, 0);
    // output 2: CLR, MAC tap0, tap1, then stop at tap2
    repeat (3) tick();
    #1;
    n_tests++;
    if ({flags, mem_addr_x, rom_addr_f} !== {6'b000101, 3'd4, 2'd2}) begin
      n_fail++;
      $display("FAIL mac_tap2: flags=%b addr=%0d rom=%0d want flags=000101 addr=4 rom=2",
               flags, mem_addr_x, rom_addr_f);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({flags, mem_addr_x, rom_addr_f} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want all zero", {flags, mem_addr_x, rom_addr_f});
    end
    tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if ({flags, mem_addr_x} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b want all zero", {flags, mem_addr_x});
    end
    tick();
    test_load("reload", 1'b0);
    run_output(0, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    n_accepts = 0;
    test_reset();
    test_load("load", 1'b0);
    test_backpressure();
    test_full_run();
    test_load("load_gaps", 1'b1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
